// File: rtl/ufm_read_arbiter_if.sv
`timescale 1ns/1ps
// Client and engine signals of the UFM read arbiter, grouped as one bundle.
// The arbiter uses the slave view; requesters plus the read engine sit on the master view.
interface ufm_read_arbiter_if #(
  parameter int NUM_CLIENTS = 4
);
  logic [NUM_CLIENTS-1:0]    req;
  logic [11*NUM_CLIENTS-1:0] req_addr;
  logic [NUM_CLIENTS-1:0]    grant;
  logic [7:0]                cl_data;
  logic [NUM_CLIENTS-1:0]    cl_data_stb;
  logic [3:0]                cl_byte_idx;
  logic [NUM_CLIENTS-1:0]    done;
  logic [NUM_CLIENTS-1:0]    err;
  logic                      busy;
  logic                      rdr_start;
  logic [10:0]               rdr_addr;
  logic [7:0]                rdr_data;
  logic                      rdr_data_stb;
  logic                      rdr_ready;

  modport slave (
    input  req, req_addr, rdr_data, rdr_data_stb, rdr_ready,
    output grant, cl_data, cl_data_stb, cl_byte_idx, done, err, busy,
           rdr_start, rdr_addr
  );

  modport master (
    output req, req_addr, rdr_data, rdr_data_stb, rdr_ready,
    input  grant, cl_data, cl_data_stb, cl_byte_idx, done, err, busy,
           rdr_start, rdr_addr
  );
endinterface

// File: rtl/ufm_read_arbiter.sv
`timescale 1ns/1ps
// Round-robin sharing of one UFM page-read engine among NUM_CLIENTS requesters, steering
// page bytes to the owner; a watchdog aborts the client handshake if the engine stalls.
module ufm_read_arbiter #(
  parameter int NUM_CLIENTS    = 4,
  parameter int PAGE_BYTES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  ufm_read_arbiter_if.slave bus
);

  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, ISSUE, STREAM, FINISH, DRAIN} state_t;

  state_t                 state;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          gidx;
  logic [IW-1:0]          next_ptr;
  logic [4:0]             byte_cnt;
  logic [WW-1:0]          wdog;
  logic [NUM_CLIENTS-1:0] grant_q;
  logic [NUM_CLIENTS-1:0] done_q;
  logic [NUM_CLIENTS-1:0] err_q;
  logic                   busy_q;
  logic                   start_q;
  logic [10:0]            addr_q;

  logic                   pick_vld;
  logic [IW-1:0]          pick_idx;
  logic [NUM_CLIENTS-1:0] pick_oh;
  logic [10:0]            pick_addr;
  logic                   stb_fwd;

  // First requester at or after rr_ptr, wrapping around the client ring.
  always_comb begin
    int j;
    j         = 0;
    pick_vld  = 1'b0;
    pick_idx  = '0;
    pick_oh   = '0;
    pick_addr = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_CLIENTS) j = j - NUM_CLIENTS;
      if (!pick_vld && bus.req[j]) begin
        pick_vld   = 1'b1;
        pick_idx   = IW'(j);
        pick_oh[j] = 1'b1;
        pick_addr  = bus.req_addr[11*j +: 11];
      end
    end
  end

  assign next_ptr = (gidx == IW'(NUM_CLIENTS-1)) ? '0 : gidx + IW'(1);

  // Late strobes (DRAIN) and strobes outside a transaction never reach the clients.
  assign stb_fwd          = (state == STREAM) && bus.rdr_data_stb;
  assign bus.cl_data      = stb_fwd ? bus.rdr_data : 8'h00;
  assign bus.cl_data_stb  = stb_fwd ? grant_q : '0;
  assign bus.cl_byte_idx  = stb_fwd ? byte_cnt[3:0] : 4'h0;
  assign bus.grant        = grant_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.busy         = busy_q;
  assign bus.rdr_start    = start_q;
  assign bus.rdr_addr     = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gidx     <= '0;
      byte_cnt <= '0;
      wdog     <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      addr_q   <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_oh;
            gidx    <= pick_idx;
            addr_q  <= pick_addr;
            busy_q  <= 1'b1;
            state   <= ISSUE;
          end
        end
        // An idle engine holds rdr_ready until it sees start, so the registered pulse is safe.
        ISSUE: begin
          if (bus.rdr_ready) begin
            start_q  <= 1'b1;
            wdog     <= '0;
            byte_cnt <= '0;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (bus.rdr_data_stb) begin
            byte_cnt <= byte_cnt + 5'd1;
            wdog     <= '0;
            if (byte_cnt == 5'(PAGE_BYTES-1)) begin
              done_q <= grant_q;
              state  <= FINISH;
            end
          end else if (wdog == WW'(TIMEOUT_CYCLES-1)) begin
            err_q <= grant_q;
            state <= DRAIN;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        FINISH: state <= DRAIN;
        DRAIN: begin
          if (bus.rdr_ready) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            rr_ptr  <= next_ptr;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ufm_read_arbiter.sv
`timescale 1ns/1ps
// Randomized bench for ufm_read_arbiter: an engine model feeds pages, a round-robin reference
// model predicts owners, and a monitor scores every grant, byte, done and err against a queue.
module tb_ufm_read_arbiter;
  localparam int N  = 4;
  localparam int PB = 16;
  localparam int T  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic eng_ready = 1'b1;
  logic hold_off  = 1'b0;

  ufm_read_arbiter_if #(.NUM_CLIENTS(N)) bus();
  ufm_read_arbiter #(.NUM_CLIENTS(N), .PAGE_BYTES(PB), .TIMEOUT_CYCLES(T))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  assign bus.rdr_ready = eng_ready & ~hold_off;

  typedef struct {
    int          client;
    logic [10:0] addr;
    int          nbytes;
    bit          timeout;
  } txn_t;

  txn_t        exp_q[$];
  logic [7:0]  byte_q[$];
  logic [10:0] addr_tab[N];
  int checks = 0, passes = 0;
  int model_ptr = 0;

  // Engine behaviour knobs, applied to the engine start whose ordinal matches *_for.
  int eng_starts = 0;
  int stall_for = -1, stall_after = PB, stall_len = 0;
  int base_for = -1, data_base = 0;

  int cyc = 0, last_stb = 0, grants_seen = 0, mon_bytes = 0, mon_starts = 0;
  bit mon_have = 0, mon_fin = 0, prev_ready = 0;
  txn_t cur;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act == want) passes++;
    else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, want, want);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act >= lo && act <= hi) passes++;
    else $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addrs();
    for (int i = 0; i < N; i++) bus.req_addr[11*i +: 11] = addr_tab[i];
  endtask

  function automatic int rr_pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(model_ptr + k) % N]) return (model_ptr + k) % N;
    return -1;
  endfunction

  task automatic expect_txn(input logic [N-1:0] r, input bit to, input int nb);
    int w;
    w = rr_pick(r);
    exp_q.push_back('{client: w, addr: addr_tab[w], nbytes: nb, timeout: to});
    model_ptr = (w + 1) % N;
  endtask

  task automatic wait_grants(input int target);
    int b;
    b = 3000;
    while (grants_seen < target && b > 0) begin @(negedge clk); b--; end
    if (grants_seen < target) chk("grant_wait", grants_seen, target);
  endtask

  task automatic wait_bytes(input int n);
    int b;
    b = 3000;
    while (mon_bytes < n && b > 0) begin @(negedge clk); b--; end
    if (mon_bytes < n) chk("byte_wait", mon_bytes, n);
  endtask

  task automatic wait_idle();
    int b;
    b = 5000;
    while ((mon_have || exp_q.size() != 0 || bus.busy) && b > 0) begin @(negedge clk); b--; end
    if (b == 0) chk("idle_wait", int'(mon_have) + exp_q.size() + int'(bus.busy), 0);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    bus.req = '0;
    hold_off = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    byte_q.delete();
    model_ptr = 0;
    rst = 1'b0;
  endtask

  task automatic eng_step(input logic stb, input logic [7:0] d, input logic rdy, inout bit ab);
    if (ab) return;
    tick();
    if (rst) begin
      ab = 1'b1;
      bus.rdr_data_stb = 1'b0;
      eng_ready = 1'b1;
    end else begin
      bus.rdr_data_stb = stb;
      bus.rdr_data = d;
      eng_ready = rdy;
    end
  endtask

  // Engine model: on start, drop ready, deliver a page with random gaps, optionally stall, then idle.
  initial begin
    bus.rdr_data_stb = 1'b0;
    bus.rdr_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && bus.rdr_start) begin
        bit ab;
        int sa, sl, db;
        logic [7:0] d;
        ab = 1'b0;
        sa = (eng_starts == stall_for) ? stall_after : PB;
        sl = stall_len;
        db = (eng_starts == base_for) ? data_base : -1;
        eng_starts++;
        eng_step(1'b0, 8'h00, 1'b0, ab);
        repeat (int'($urandom_range(0, 3))) eng_step(1'b0, 8'h00, 1'b0, ab);
        for (int b = 0; b < PB; b++) begin
          if (b == sa) repeat (sl) eng_step(1'b0, 8'h00, 1'b0, ab);
          d = (db >= 0) ? 8'(db + b) : 8'($urandom);
          eng_step(1'b1, d, 1'b0, ab);
          if (!ab && b < sa) byte_q.push_back(d);
          repeat (int'($urandom_range(0, 3))) eng_step(1'b0, 8'h00, 1'b0, ab);
        end
        eng_step(1'b0, 8'h00, 1'b0, ab);
        repeat (int'($urandom_range(1, 4))) eng_step(1'b0, 8'h00, 1'b0, ab);
        eng_step(1'b0, 8'h00, 1'b1, ab);
      end
    end
  end

  // Monitor: pops the expected owner at each new grant, then scores all client-facing traffic.
  initial begin
    int oh;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mon_have = 1'b0;
        mon_bytes = 0;
      end else begin
        if (!mon_have && bus.grant != '0) begin
          grants_seen++;
          chk("grant_queued", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            mon_have = 1'b1;
            mon_bytes = 0;
            mon_starts = 0;
            mon_fin = 1'b0;
            chk("grant_owner", int'(bus.grant), 1 << cur.client);
            chk("busy_at_grant", int'(bus.busy), 1);
          end
        end
        if (mon_have) begin
          oh = 1 << cur.client;
          if (bus.grant != '0) chk("grant_stable", int'(bus.grant), oh);
          if (bus.rdr_start) begin
            chk("start_while_ready", int'(prev_ready & bus.rdr_ready), 1);
            chk("start_once", mon_starts, 0);
            chk("rdr_addr", int'(bus.rdr_addr), int'(cur.addr));
            mon_starts++;
          end
          if (bus.cl_data_stb != '0) begin
            chk("stb_owner", int'(bus.cl_data_stb), oh);
            chk("stb_expected", int'(byte_q.size() > 0), 1);
            if (byte_q.size() > 0) chk("cl_data", int'(bus.cl_data), int'(byte_q.pop_front()));
            chk("byte_idx", int'(bus.cl_byte_idx), mon_bytes);
            mon_bytes++;
            last_stb = cyc;
          end
          if (bus.done != '0) begin
            chk("done_owner", int'(bus.done), oh);
            chk("done_not_timeout", int'(cur.timeout), 0);
            chk("done_byte_count", mon_bytes, PB);
            mon_fin = 1'b1;
          end
          if (bus.err != '0) begin
            chk("err_owner", int'(bus.err), oh);
            chk("err_expected", int'(cur.timeout), 1);
            chk("err_byte_count", mon_bytes, cur.nbytes);
            chk_range("err_latency", cyc - last_stb, T, T + 1);
            mon_fin = 1'b1;
          end
          if (bus.grant == '0) begin
            chk("finished_before_release", int'(mon_fin), 1);
            chk("ready_at_release", int'(prev_ready), 1);
            chk("busy_at_release", int'(bus.busy), 0);
            chk("started_once", mon_starts, 1);
            mon_have = 1'b0;
          end
        end else begin
          chk("quiet_when_idle", int'({bus.done, bus.err, bus.cl_data_stb}), 0);
        end
      end
      prev_ready = bus.rdr_ready;
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: stuck at cycle %0d, %0d/%0d checks passed so far", cyc, passes, checks);
    $fatal(1, "bench timed out");
  end

  // Stimulus and reference model.
  initial begin
    int gb;
    logic [10:0] orig;
    bus.req = '0;
    bus.req_addr = '0;
    for (int i = 0; i < N; i++) addr_tab[i] = 11'h000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_start", int'(bus.rdr_start), 0);
    chk("rst_rdr_addr", int'(bus.rdr_addr), 0);
    chk("rst_outs", int'({bus.cl_data_stb, bus.done, bus.err, bus.cl_data, bus.cl_byte_idx}), 0);
    tick();
    rst = 1'b0;

    // Single client with a known byte pattern; exact grant and start latency.
    tick();
    addr_tab[2] = 11'h123;
    set_addrs();
    base_for = eng_starts;
    data_base = 8'hA0;
    bus.req = 4'b0100;
    expect_txn(4'b0100, 1'b0, PB);
    @(negedge clk);
    @(negedge clk);
    chk("single_grant_lat1", int'(bus.grant), 4);
    chk("single_busy", int'(bus.busy), 1);
    @(negedge clk);
    chk("single_start_lat2", int'(bus.rdr_start), 1);
    chk("single_addr", int'(bus.rdr_addr), 11'h123);
    tick();
    bus.req = '0;
    wait_idle();

    // Contention from a fresh pointer: four full pages.
    do_reset();
    tick();
    for (int i = 0; i < N; i++) addr_tab[i] = 11'($urandom);
    set_addrs();
    gb = grants_seen;
    bus.req = 4'b1011;
    for (int i = 0; i < 4; i++) expect_txn(4'b1011, 1'b0, PB);
    wait_grants(gb + 4);
    tick();
    bus.req = '0;
    wait_idle();

    // Engine busy at grant; address change during the transaction must not leak.
    tick();
    hold_off = 1'b1;
    addr_tab[1] = 11'($urandom);
    orig = addr_tab[1];
    set_addrs();
    gb = grants_seen;
    bus.req = 4'b0010;
    expect_txn(4'b0010, 1'b0, PB);
    wait_grants(gb + 1);
    tick();
    bus.req_addr[11 +: 11] = ~orig;
    repeat (10) tick();
    hold_off = 1'b0;
    @(negedge clk);
    chk("start_held_off", int'(bus.rdr_start), 0);
    @(negedge clk);
    chk("start_first_ready", int'(bus.rdr_start), 1);
    wait_bytes(8);
    chk("rdr_addr_held", int'(bus.rdr_addr), int'(orig));
    tick();
    bus.req = '0;
    wait_idle();

    // Engine stalls after 5 bytes: err, no done, late bytes dropped, next owner waits.
    tick();
    for (int i = 0; i < N; i++) addr_tab[i] = 11'($urandom);
    set_addrs();
    stall_for = eng_starts;
    stall_after = 5;
    stall_len = 45;
    gb = grants_seen;
    bus.req = 4'b0101;
    expect_txn(4'b0101, 1'b1, 5);
    expect_txn(4'b0101, 1'b0, PB);
    wait_grants(gb + 2);
    tick();
    bus.req = '0;
    wait_idle();

    // Owner drops its request mid-page.
    begin
      logic [N-1:0] p;
      int w;
      tick();
      p = 4'b1010;
      w = rr_pick(p);
      gb = grants_seen;
      bus.req = p;
      expect_txn(p, 1'b0, PB);
      wait_grants(gb + 1);
      wait_bytes(3);
      tick();
      p[w] = 1'b0;
      bus.req = p;
      expect_txn(p, 1'b0, PB);
      wait_grants(gb + 2);
      tick();
      bus.req = '0;
      wait_idle();
    end

    // Random request sets, each held for a random number of grants.
    for (int r = 0; r < 12; r++) begin
      logic [N-1:0] pat;
      int k;
      pat = N'($urandom_range(1, (1 << N) - 1));
      k = int'($urandom_range(1, 3));
      tick();
      for (int i = 0; i < N; i++) addr_tab[i] = 11'($urandom);
      set_addrs();
      gb = grants_seen;
      bus.req = pat;
      for (int i = 0; i < k; i++) expect_txn(pat, 1'b0, PB);
      wait_grants(gb + k);
      tick();
      bus.req = '0;
      wait_idle();
    end

    // Reset during streaming, then a fresh arbitration from pointer 0.
    tick();
    gb = grants_seen;
    bus.req = 4'b0110;
    expect_txn(4'b0110, 1'b0, PB);
    wait_grants(gb + 1);
    wait_bytes(7);
    tick();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_grant", int'(bus.grant), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_stb", int'(bus.cl_data_stb), 0);
    chk("midrst_pulses", int'({bus.done, bus.err, bus.rdr_start}), 0);
    bus.req = '0;
    tick();
    tick();
    exp_q.delete();
    byte_q.delete();
    model_ptr = 0;
    rst = 1'b0;
    tick();
    gb = grants_seen;
    bus.req = 4'b1111;
    expect_txn(4'b1111, 1'b0, PB);
    wait_grants(gb + 1);
    tick();
    bus.req = '0;
    wait_idle();

    chk("exp_q_drained", exp_q.size(), 0);
    chk("byte_q_drained", byte_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
